// File: rtl/paddle_pkg.sv
// -----------------------------------------------------------------------------
// paddle_pkg
// Shared constants and helpers for the paddle_bank encoder front end.
//   - Gray-code quadrature states Q00/Q01/Q11/Q10
//   - Decoded direction encoding (DIR_UP=+1, DIR_DN=-1, DIR_NONE=0, DIR_ERR)
//   - Default screen geometry used to derive the position limits
//   - quad_dir(): classifies one filtered-state transition
// -----------------------------------------------------------------------------
package paddle_pkg;

    localparam logic [1:0] Q00 = 2'b00;
    localparam logic [1:0] Q01 = 2'b01;
    localparam logic [1:0] Q11 = 2'b11;
    localparam logic [1:0] Q10 = 2'b10;

    // DIR_UP/DIR_DN read as 2-bit two's complement +1/-1.
    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_ERR  = 2'b10,
        DIR_DN   = 2'b11
    } dir_e;

    localparam int unsigned SCREEN_H      = 480;
    localparam int unsigned PADDLE_H      = 64;
    localparam int unsigned POS_MAX_DEF   = SCREEN_H - PADDLE_H;
    localparam int unsigned POS_INIT_DEF  = POS_MAX_DEF / 2;

    // Forward sequence is 00 -> 01 -> 11 -> 10 -> 00.
    function automatic dir_e quad_dir(input logic [1:0] old_s, input logic [1:0] new_s);
        dir_e d;
        case ({old_s, new_s})
            {Q00, Q01}, {Q01, Q11}, {Q11, Q10}, {Q10, Q00}: d = DIR_UP;
            {Q01, Q00}, {Q11, Q01}, {Q10, Q11}, {Q00, Q10}: d = DIR_DN;
            {Q00, Q11}, {Q11, Q00}, {Q01, Q10}, {Q10, Q01}: d = DIR_ERR;
            default:                                        d = DIR_NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/paddle_bank_quad_decoder.sv
// -----------------------------------------------------------------------------
// quad_decoder
// One encoder channel: 2-FF synchroniser, glitch filter and Gray decode.
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   enc_a_i  in   encoder phase A (asynchronous)
//   enc_b_i  in   encoder phase B (asynchronous)
//   step_o   out  one-cycle strobe: a legal count was decoded
//   dir_o    out  direction of that count (paddle_pkg::dir_e encoding)
//   ill_o    out  one-cycle strobe: both phases changed at once
// -----------------------------------------------------------------------------
module quad_decoder
    import paddle_pkg::*;
#(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enc_a_i,
    input  logic       enc_b_i,
    output logic       step_o,
    output logic [1:0] dir_o,
    output logic       ill_o
);

    localparam logic [3:0] FILT_THR = 4'(FILT_LEN);

    logic [1:0] sync1_q, sync2_q;
    logic [1:0] filt_q, cand_q;
    logic [3:0] cnt_q;
    logic [3:0] run_d;
    logic       accept_d;
    dir_e       dir_new_d;
    dir_e       dir_q;
    logic       step_q, ill_q;

    always_comb begin
        // Length of the current run of identical synchronised samples,
        // including the present one.
        run_d = 4'd1;
        if ((sync2_q == cand_q) && (cnt_q != 4'd0)) begin
            run_d = cnt_q + 4'd1;
        end
        accept_d  = (sync2_q != filt_q) && (run_d >= FILT_THR);
        dir_new_d = quad_dir(filt_q, sync2_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= Q00;
            cand_q  <= Q00;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            ill_q   <= 1'b0;
            dir_q   <= DIR_NONE;
        end else begin
            sync1_q <= {enc_a_i, enc_b_i};
            sync2_q <= sync1_q;
            step_q  <= 1'b0;
            ill_q   <= 1'b0;
            dir_q   <= DIR_NONE;
            if (sync2_q == filt_q) begin
                cnt_q <= '0;
            end else if (accept_d) begin
                filt_q <= sync2_q;
                cnt_q  <= '0;
                dir_q  <= dir_new_d;
                step_q <= (dir_new_d == DIR_UP) || (dir_new_d == DIR_DN);
                ill_q  <= (dir_new_d == DIR_ERR);
            end else begin
                cand_q <= sync2_q;
                cnt_q  <= run_d;
            end
        end
    end

    assign step_o = step_q;
    assign dir_o  = dir_q;
    assign ill_o  = ill_q;

endmodule

// File: rtl/paddle_bank.sv
// -----------------------------------------------------------------------------
// paddle_bank
// Decodes CHANNELS quadrature encoders into clamped paddle positions that
// only change on the vsync rising edge (no mid-frame tearing).
//   clk      in   pixel clock
//   rst_n    in   asynchronous active-low reset
//   enc_a    in   [CHANNELS]  encoder phase A per channel (asynchronous)
//   enc_b    in   [CHANNELS]  encoder phase B per channel (asynchronous)
//   vsync    in   vertical sync; rising edge is the frame tick
//   pos      out  [CHANNELS*POS_W] packed positions, channel i at [i*POS_W +: POS_W]
//   pos_upd  out  one-cycle pulse, the cycle after pos was updated
//   err      out  [CHANNELS] sticky illegal-transition flags
//   err_clr  in   synchronous clear of all err bits (a new error wins)
// Optional build macro: PADDLE_ACCEL_EN doubles the move when |delta| >= 4.
// -----------------------------------------------------------------------------
module paddle_bank
    import paddle_pkg::*;
#(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned POS_W    = 10,
    parameter int unsigned POS_MIN  = 0,
    parameter int unsigned POS_MAX  = POS_MAX_DEF,
    parameter int unsigned POS_INIT = POS_INIT_DEF,
    parameter int unsigned STEP     = 4,
    parameter int unsigned FILT_LEN = 3,
    parameter int unsigned DELTA_W  = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       enc_a,
    input  logic [CHANNELS-1:0]       enc_b,
    input  logic                      vsync,
    output logic [CHANNELS*POS_W-1:0] pos,
    output logic                      pos_upd,
    output logic [CHANNELS-1:0]       err,
    input  logic                      err_clr
);

    localparam int unsigned EXT_W = POS_W + DELTA_W + 3;

    localparam logic signed [DELTA_W:0]   SAT_HI = (DELTA_W+1)'((1 << (DELTA_W-1)) - 1);
    localparam logic signed [DELTA_W:0]   SAT_LO = -SAT_HI;
    localparam logic signed [EXT_W-1:0]   STEP_X = EXT_W'(STEP);
    localparam logic signed [EXT_W-1:0]   LIM_LO = EXT_W'(POS_MIN);
    localparam logic signed [EXT_W-1:0]   LIM_HI = EXT_W'(POS_MAX);
`ifdef PADDLE_ACCEL_EN
    localparam logic signed [DELTA_W-1:0] ACC_TH = DELTA_W'(4);
`endif

    logic vsync_q;
    logic pos_upd_q;
    logic tick;

    assign tick = vsync & ~vsync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q   <= 1'b0;
            pos_upd_q <= 1'b0;
        end else begin
            vsync_q   <= vsync;
            pos_upd_q <= tick;
        end
    end

    assign pos_upd = pos_upd_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic                      step;
        logic [1:0]                dir;
        logic                      ill;
        logic signed [DELTA_W-1:0] delta_q, delta_d;
        logic signed [DELTA_W-1:0] inc;
        logic signed [DELTA_W:0]   sum_w;
        logic signed [EXT_W-1:0]   mv;
        logic signed [EXT_W-1:0]   tgt;
        logic [POS_W-1:0]          pos_q, pos_d;
        logic                      err_q, err_d;

        quad_decoder #(
            .FILT_LEN (FILT_LEN)
        ) u_dec (
            .clk     (clk),
            .rst_n   (rst_n),
            .enc_a_i (enc_a[g]),
            .enc_b_i (enc_b[g]),
            .step_o  (step),
            .dir_o   (dir),
            .ill_o   (ill)
        );

        always_comb begin
            inc = '0;
            if (step) begin
                inc = (dir == DIR_DN) ? '1 : DELTA_W'(1);
            end

            // One guard bit is enough to detect leaving the symmetric range.
            sum_w = {delta_q[DELTA_W-1], delta_q} + {inc[DELTA_W-1], inc};
            if (sum_w > SAT_HI) begin
                sum_w = SAT_HI;
            end else if (sum_w < SAT_LO) begin
                sum_w = SAT_LO;
            end

            // A count arriving in the tick cycle seeds the next frame.
            delta_d = tick ? inc : sum_w[DELTA_W-1:0];

            mv = EXT_W'(delta_q) * STEP_X;
`ifdef PADDLE_ACCEL_EN
            if ((delta_q >= ACC_TH) || (delta_q <= -ACC_TH)) begin
                mv = {mv[EXT_W-2:0], 1'b0};
            end
`endif
            tgt = {{(EXT_W-POS_W){1'b0}}, pos_q} + mv;
            if (tgt < LIM_LO) begin
                pos_d = POS_W'(POS_MIN);
            end else if (tgt > LIM_HI) begin
                pos_d = POS_W'(POS_MAX);
            end else begin
                pos_d = tgt[POS_W-1:0];
            end

            err_d = (err_q & ~err_clr) | ill;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pos_q   <= POS_W'(POS_INIT);
                delta_q <= '0;
                err_q   <= 1'b0;
            end else begin
                delta_q <= delta_d;
                err_q   <= err_d;
                if (tick) begin
                    pos_q <= pos_d;
                end
            end
        end

        assign pos[g*POS_W +: POS_W] = pos_q;
        assign err[g]                = err_q;
    end

endmodule

// File: tb/tb_paddle_bank.sv
// -----------------------------------------------------------------------------
// tb_paddle_bank
// Scoreboard bench for paddle_bank: frame ticks push the expected positions
// computed by an arithmetic reference model; a monitor pops and compares on
// every pos_upd pulse.
// -----------------------------------------------------------------------------
module tb_paddle_bank;

    localparam int CH    = 2;
    localparam int POS_W = 10;
    localparam int PMIN  = 0;
    localparam int PMAX  = 416;
    localparam int PINIT = 208;
    localparam int STEP  = 4;
    localparam int FILT  = 3;
    localparam int DMAX  = 31;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [CH-1:0]          enc_a = '0;
    logic [CH-1:0]          enc_b = '0;
    logic                   vsync = 1'b0;
    logic                   err_clr = 1'b0;
    logic [CH*POS_W-1:0]    pos;
    logic                   pos_upd;
    logic [CH-1:0]          err;

    paddle_bank #(
        .CHANNELS (CH),
        .POS_W    (POS_W),
        .POS_MIN  (PMIN),
        .POS_MAX  (PMAX),
        .POS_INIT (PINIT),
        .STEP     (STEP),
        .FILT_LEN (FILT),
        .DELTA_W  (6)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .vsync   (vsync),
        .pos     (pos),
        .pos_upd (pos_upd),
        .err     (err),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int upd_seen = 0;

    // Reference model state: position, pending count, index in the Gray
    // cycle 00,01,11,10 currently presented on the pins, sticky error.
    int mpos[CH];
    int mdelta[CH];
    int midx[CH];
    bit merr[CH];
    logic [CH*POS_W-1:0] expq[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [1:0] gray(input int idx);
        case (idx)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            mpos[c] = PINIT; mdelta[c] = 0; midx[c] = 0; merr[c] = 1'b0;
        end
    endtask

    task automatic model_count(input int c, input int d);
        mdelta[c] = mdelta[c] + d;
        if (mdelta[c] > DMAX)  mdelta[c] = DMAX;
        if (mdelta[c] < -DMAX) mdelta[c] = -DMAX;
    endtask

    task automatic model_tick();
        logic [CH*POS_W-1:0] e;
        int mv;
        e = '0;
        for (int c = 0; c < CH; c++) begin
            mv = mdelta[c] * STEP;
`ifdef PADDLE_ACCEL_EN
            if (mdelta[c] >= 4 || mdelta[c] <= -4) mv = mv * 2;
`endif
            mpos[c] = mpos[c] + mv;
            if (mpos[c] < PMIN) mpos[c] = PMIN;
            if (mpos[c] > PMAX) mpos[c] = PMAX;
            mdelta[c] = 0;
            e[c*POS_W +: POS_W] = POS_W'(mpos[c]);
        end
        expq.push_back(e);
    endtask

    task automatic drive_pins(input int c);
        logic [1:0] g;
        g = gray(midx[c]);
        enc_a[c] = g[1];
        enc_b[c] = g[0];
    endtask

    // d = +1 forward, -1 reverse, 2 both-bit jump (illegal)
    task automatic step(input int c, input int d, input int hold);
        midx[c] = (midx[c] + d + 4) % 4;
        drive_pins(c);
        if (d == 2) merr[c] = 1'b1;
        else        model_count(c, d);
        wait_cyc(hold);
    endtask

    task automatic glitch(input int c);
        enc_a[c] = ~enc_a[c];
        wait_cyc(1);
        enc_a[c] = ~enc_a[c];
        wait_cyc(5);
    endtask

    task automatic check_err();
        for (int c = 0; c < CH; c++) begin
            check($sformatf("err%0d", c), int'(err[c]), int'(merr[c]));
        end
    endtask

    task automatic do_tick();
        wait_cyc(8);
        check_err();
        vsync = 1'b1;
        model_tick();
        wait_cyc(1);
        vsync = 1'b0;
        wait_cyc(3);
    endtask

    // Monitor: every pos_upd pulse consumes one expected frame.
    always @(negedge clk) begin
        if (rst_n && pos_upd) begin
            logic [CH*POS_W-1:0] e;
            upd_seen++;
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pos_upd: got pulse expected none");
            end else begin
                e = expq.pop_front();
                for (int c = 0; c < CH; c++) begin
                    check($sformatf("pos%0d", c), int'(pos[c*POS_W +: POS_W]),
                          int'(e[c*POS_W +: POS_W]));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        wait_cyc(3);
        for (int c = 0; c < CH; c++) begin
            check($sformatf("rst_pos%0d", c), int'(pos[c*POS_W +: POS_W]), PINIT);
        end
        check("rst_pos_upd", int'(pos_upd), 0);
        check("rst_err", int'(err), 0);
        rst_n = 1'b1;
        wait_cyc(2);

        // Idle frames
        repeat (3) do_tick();
        check("idle_upd_count", upd_seen, 3);

        // Channel 0 forward
        repeat (5) step(0, 1, 4);
        do_tick();

        // Channel 1 reverse, saturating, then pinned at POS_MIN
        repeat (3) begin
            repeat (60) step(1, -1, 4);
            do_tick();
        end

        // Single-cycle glitch must not count
        glitch(0);
        do_tick();

        // Illegal jump from 00
        while (midx[0] != 0) step(0, 1, 4);
        step(0, 2, 4);
        wait_cyc(6);
        check("err_set", int'(err[0]), 1);
        err_clr = 1'b1;
        wait_cyc(1);
        err_clr = 1'b0;
        merr[0] = 1'b0;
        check("err_clr", int'(err[0]), 0);

        // Illegal step filtered in the same cycle err_clr is asserted
        midx[0] = (midx[0] + 2) % 4;
        drive_pins(0);
        merr[0] = 1'b1;
        wait_cyc(2 + FILT);
        err_clr = 1'b1;
        wait_cyc(1);
        err_clr = 1'b0;
        wait_cyc(2);
        check("err_set_wins", int'(err[0]), 1);
        do_tick();

        // Forward step decoded exactly in the tick cycle
        wait_cyc(8);
        midx[0] = (midx[0] + 1) % 4;
        drive_pins(0);
        wait_cyc(2 + FILT);
        vsync = 1'b1;
        model_tick();
        model_count(0, 1);
        wait_cyc(1);
        vsync = 1'b0;
        wait_cyc(3);
        do_tick();

        // Reset mid-frame discards pending counts
        repeat (4) step(0, 1, 4);
        repeat (4) step(1, 1, 4);
        wait_cyc(8);
        rst_n = 1'b0;
        enc_a = '0;
        enc_b = '0;
        model_reset();
        wait_cyc(3);
        check("midrst_pos0", int'(pos[0 +: POS_W]), PINIT);
        check("midrst_err", int'(err), 0);
        rst_n = 1'b1;
        wait_cyc(4);
        do_tick();

        // Randomised frames
        for (int f = 0; f < 12; f++) begin
            int nops;
            nops = int'($urandom_range(0, 25));
            for (int k = 0; k < nops; k++) begin
                int c;
                int r;
                c = int'($urandom_range(0, CH - 1));
                r = int'($urandom_range(0, 19));
                if (r < 9)       step(c, 1, int'($urandom_range(4, 7)));
                else if (r < 18) step(c, -1, int'($urandom_range(4, 7)));
                else if (r < 19) step(c, 2, 4);
                else             glitch(c);
            end
            do_tick();
        end

        err_clr = 1'b1;
        wait_cyc(1);
        err_clr = 1'b0;
        for (int c = 0; c < CH; c++) merr[c] = 1'b0;
        wait_cyc(2);
        check_err();

        wait_cyc(4);
        if (expq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL pending_frames: got %0d unconsumed expected 0", expq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/paddle_bank.md
Name: paddle_bank

Overview:
- Parametrised successor to the single-paddle quadrature mover: decodes CHANNELS rotary encoders into clamped, frame-synchronous paddle positions.
- Adds input synchronisation, glitch filtering, illegal-transition detection and per-frame accumulation.
- Sits between ui_in encoder pins and the pong game logic.
- Positions change only at vsync rising edge, so a paddle never tears mid-frame.

Parameters:
- CHANNELS, 2, number of encoder/paddle channels.
- POS_W, 10, position width in bits (unsigned).
- POS_MIN, 0, lowest legal position.
- POS_MAX, 416, highest legal position (480-line screen minus 64-line paddle).
- POS_INIT, 208, position after reset.
- STEP, 4, pixels moved per decoded quadrature count.
- FILT_LEN, 3, consecutive identical synchronised samples required before an input change is accepted (1..15).
- DELTA_W, 6, signed per-frame count accumulator width.

Ports:
- clk  in  1  system clock (pixel clock).
- rst_n  in  1  asynchronous active-low reset; deassertion assumed synchronous to clk upstream.
- enc_a  in  CHANNELS  encoder phase A, one bit per channel, asynchronous.
- enc_b  in  CHANNELS  encoder phase B, one bit per channel, asynchronous.
- vsync  in  1  vertical sync from hvsync_generator; rising edge is the frame tick.
- pos  out  CHANNELS*POS_W  packed positions; channel i at [i*POS_W +: POS_W].
- pos_upd  out  1  one-cycle pulse, the cycle after pos is updated.
- err  out  CHANNELS  sticky illegal-transition flag per channel.
- err_clr  in  1  synchronous clear of all err bits.

Behaviour:
- Reset values: pos = POS_INIT for every channel; pos_upd = 0; err = 0; accumulators = 0; filter state = 00; vsync edge register = 0.
- Sync: per channel, 2-FF synchroniser on {a,b}.
- Filter: counter per channel. A synchronised {a,b} differing from the filtered state must hold for FILT_LEN consecutive cycles before it becomes the new filtered state. Any change in the candidate value restarts the count.
- Decode, on each filtered-state change (old->new):
  - 00->01, 01->11, 11->10, 10->00: +1.
  - Reverse sequence: -1.
  - Both bits changed (00<->11, 01<->10): no count; err[i] set.
  - Updates the filter state regardless.
- Accumulator: signed DELTA_W, saturating at +(2^(DELTA_W-1)-1) and -(2^(DELTA_W-1)-1); never wraps.
- Frame tick: registered vsync 0->1. In the tick cycle, for each channel:
  - pos <= clamp(pos + delta*STEP, POS_MIN, POS_MAX), computed signed at POS_W+DELTA_W+3 bits.
  - delta <= 0.
  - pos_upd pulses high the following cycle.
- Tick coincident with a decode count: the count is not lost; delta loads ±1 instead of 0 and is applied next frame.
- err_clr and a new illegal transition in the same cycle: err stays set (set wins).
- Reset mid-frame discards pending delta; pos returns to POS_INIT.
- Latency: encoder edge to pos visible = 2 (sync) + FILT_LEN + remaining frame time + 1 cycles.

Optional Feature:
- Macro PADDLE_ACCEL_EN.
- Defined: at the tick, if |delta| >= 4, the applied move is delta*STEP*2, with the same clamp.
- Undefined: always delta*STEP, and no multiplier logic is synthesised.

Decomposition:
- Package paddle_pkg holds:
  - Gray-code state localparams (Q00, Q01, Q11, Q10).
  - The direction encoding (DIR_UP=+1, DIR_DN=-1, DIR_NONE=0, DIR_ERR).
  - The default screen constants (480, paddle height 64).
- Sub-module quad_decoder: one channel of sync + filter + Gray decode. Outputs a count strobe, direction and illegal strobe.
- paddle_bank generates CHANNELS quad_decoder instances and owns the accumulators, clamp and frame logic.

Test Plan:
- Reset then 3 vsync ticks, no encoder activity -> pos = 208 on both channels; pos_upd pulses 3 times; err = 0.
- Channel 0: 5 forward Gray steps, each held 4 cycles, then tick -> pos0 = 228; pos1 = 208.
- Channel 1: 60 reverse steps in one frame -> delta saturates at -31; pos1 = clamp(208-124) = 84. Repeat two frames -> pos1 = 0, held at POS_MIN.
- Channel 0: 1-cycle glitch on enc_a with FILT_LEN=3 -> no count; pos unchanged after tick.
- Channel 0: 00->11 jump -> err[0]=1, no move; err_clr pulse -> err[0]=0; illegal step and err_clr in the same cycle -> err[0] stays 1.
- Forward step filtered exactly in the tick cycle -> current frame applies the old delta; next tick adds +4.
- With PADDLE_ACCEL_EN: 5 forward steps -> +40 instead of +20.
